build_keys_stream: RTL and testbench
====================================

Name: build_keys_stream

Overview:
- Parametrised successor of the prefix-doubling key builder in the BWT/suffix-sort datapath.
- For each string position i, emits one sort key {i, bucket[i], bucket[i+offset]} as a valid/ready stream to the downstream sorter; keys are not held in a full parallel array.
- Adds a cyclic (rotation) mode for BWT, a configurable pad symbol, offset reduction, backpressure and a start/busy/done handshake.

Parameters:
- STRING_LEN, 8, number of symbols/keys per pass; range 2..2^IDX_W.
- SYM_W, 8, width of one bucket/rank value.
- IDX_W, 8, width of position index and offset.
- PAD_SYM, 0, second-symbol value used in linear mode past the string end (SYM_W bits).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin a pass; sampled only in IDLE.
- cyclic, in, 1, 1 = wrap index mod STRING_LEN, 0 = pad; latched at start.
- offset, in, IDX_W, doubling offset; latched at start.
- buckets, in, STRING_LEN*SYM_W, flat rank vector, entry i at bits [i*SYM_W +: SYM_W]. Must be held stable from start until done; it is not snapshotted.
- key_valid, out, 1, key_data is valid.
- key_ready, in, 1, downstream accepts the key.
- key_data, out, IDX_W+2*SYM_W, {index, bucket[i], second symbol}, with index in the MSBs.
- key_last, out, 1, asserted with the key for i = STRING_LEN-1.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse after the last key is accepted.

Behaviour:
- Reset: state = IDLE; counter, offset_q and cyclic_q = 0; key_valid, key_last, busy and done = 0; key_data = 0. Reset mid-pass aborts with no further keys and no done pulse.
- States: IDLE, REDUCE, EMIT, DONE.
- IDLE, start = 1:
  - Latch offset and cyclic; counter := 0.
  - If cyclic = 1 and offset >= STRING_LEN, go to REDUCE; otherwise go to EMIT.
  - start outside IDLE is ignored.
- REDUCE:
  - Each cycle, offset_q := offset_q - STRING_LEN.
  - Go to EMIT on the cycle the result is < STRING_LEN.
  - Latency is ceil((offset - STRING_LEN + 1) / STRING_LEN) cycles.
- EMIT:
  - key_valid = 1; key_data is driven combinationally from counter and offset_q.
  - Key is stable while key_valid=1 and key_ready=0.
  - On key_valid & key_ready: counter++. If counter = STRING_LEN-1, go to DONE.
  - key_last = (counter = STRING_LEN-1).
- Second-symbol index j: computed as counter + offset_q in IDX_W+1 bits, so there is no overflow.
  - Linear mode: j < STRING_LEN gives bucket[j]; otherwise PAD_SYM (this includes offset >= STRING_LEN).
  - Cyclic mode: j < STRING_LEN gives bucket[j]; otherwise bucket[j - STRING_LEN].
- Index field: counter zero-extended/truncated to IDX_W.
- offset = 0: second symbol = bucket[i].
- DONE: done = 1 and key_valid = 0 for exactly one cycle, then IDLE. A new start is accepted on the first IDLE cycle.
- Throughput:
  - One key per cycle with key_ready held high.
  - From start to first key_valid: 1 cycle, plus REDUCE cycles if any.
  - A pass is STRING_LEN + 2 cycles minimum.
- key_valid never deasserts without a handshake, except on rst.

Test Plan:
- Linear pass: LEN=8, buckets = 10..17, offset = 2, cyclic = 0, ready always 1 → keys {0,10,12} … {5,15,17}, {6,16,0}, {7,17,0}; key_last on i=7; done 1 cycle later.
- Cyclic pass with reduction: offset = 18, cyclic = 1 → 2 REDUCE cycles with busy = 1 and key_valid = 0; then {6,16,10}, {7,17,11}; other keys match the linear pass.
- Linear pad with large offset: offset = 9, cyclic = 0, PAD_SYM = 8'hFF → all eight second symbols = 8'hFF; no REDUCE cycles.
- Backpressure: key_ready toggles 1,0,0,1,… with offset = 0 → every key is {i, b[i], b[i]}; no key is lost or duplicated; key_data is stable during stalls; exactly 8 handshakes.
- start during busy: pulse start with a different offset mid-pass → ignored; the pass completes with the original offset.
- Reset mid-pass: assert rst after key 3 → next cycle all outputs are 0 and there is no done pulse. A fresh start then produces a clean pass beginning at i = 0.

Source files
------------

// File: rtl/build_keys_stream.sv
// Prefix-doubling sort-key generator: streams {i, bucket[i], bucket[i+offset]}
// one key per handshake, with linear (padded) or cyclic (rotation) second symbol.
module build_keys_stream #(
  parameter int unsigned       STRING_LEN = 8,
  parameter int unsigned       SYM_W      = 8,
  parameter int unsigned       IDX_W      = 8,
  parameter logic [SYM_W-1:0]  PAD_SYM    = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          cyclic,
  input  logic [IDX_W-1:0]              offset,
  input  logic [STRING_LEN*SYM_W-1:0]   buckets,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [IDX_W+2*SYM_W-1:0]      key_data,
  output logic                          key_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned JW = IDX_W + 1;
  localparam logic [JW-1:0]    LEN_J    = JW'(STRING_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STRING_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_EMIT, S_DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  counter;
  logic [IDX_W-1:0]  offset_q;
  logic              cyclic_q;

  // Select one rank from the flat vector; out-of-range indices yield zero.
  function automatic logic [SYM_W-1:0] pick(input logic [JW-1:0] idx,
                                             input logic [STRING_LEN*SYM_W-1:0] vec);
    logic [SYM_W-1:0] val;
    val = '0;
    for (int unsigned k = 0; k < STRING_LEN; k++) begin
      if (idx == JW'(k)) val = vec[k*SYM_W +: SYM_W];
    end
    return val;
  endfunction

  logic [JW-1:0]     j_c;
  logic [JW-1:0]     reduced_c;
  logic [SYM_W-1:0]  first_c;
  logic [SYM_W-1:0]  second_c;

  always_comb begin
    j_c       = {1'b0, counter} + {1'b0, offset_q};
    reduced_c = {1'b0, offset_q} - LEN_J;
    first_c   = pick({1'b0, counter}, buckets);
    second_c  = PAD_SYM;
    if (j_c < LEN_J)   second_c = pick(j_c, buckets);
    else if (cyclic_q) second_c = pick(j_c - LEN_J, buckets);
  end

  // Key is only meaningful while valid; zero otherwise so reset/idle read clean.
  assign key_data = key_valid ? {counter, first_c, second_c} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      counter   <= '0;
      offset_q  <= '0;
      cyclic_q  <= 1'b0;
      key_valid <= 1'b0;
      key_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            offset_q <= offset;
            cyclic_q <= cyclic;
            counter  <= '0;
            busy     <= 1'b1;
            key_last <= 1'b0;
            if (cyclic && ({1'b0, offset} >= LEN_J)) begin
              state <= S_REDUCE;
            end else begin
              state     <= S_EMIT;
              key_valid <= 1'b1;
            end
          end
        end
        S_REDUCE: begin
          offset_q <= reduced_c[IDX_W-1:0];
          if (reduced_c < LEN_J) begin
            state     <= S_EMIT;
            key_valid <= 1'b1;
            key_last  <= 1'b0;
          end
        end
        S_EMIT: begin
          if (key_ready) begin
            counter <= counter + IDX_W'(1);
            if (counter == LAST_IDX) begin
              state     <= S_DONE;
              key_valid <= 1'b0;
              key_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              key_last <= ((counter + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_build_keys_stream.sv
// Randomised bench for build_keys_stream against a modulo/pad key model.
module tb_build_keys_stream;

  localparam int LEN   = 8;
  localparam int SYM_W = 8;
  localparam int IDX_W = 8;
  localparam logic [7:0] PAD = 8'hFF;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic                       cyclic;
  logic [IDX_W-1:0]           offset;
  logic [LEN*SYM_W-1:0]       buckets;
  logic                       key_valid;
  logic                       key_ready;
  logic [IDX_W+2*SYM_W-1:0]   key_data;
  logic                       key_last;
  logic                       busy;
  logic                       done;

  int n_checks = 0;
  int n_pass   = 0;
  int bv[LEN];

  build_keys_stream #(
    .STRING_LEN(LEN), .SYM_W(SYM_W), .IDX_W(IDX_W), .PAD_SYM(PAD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cyclic(cyclic), .offset(offset),
    .buckets(buckets), .key_valid(key_valid), .key_ready(key_ready),
    .key_data(key_data), .key_last(key_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_buckets();
    for (int i = 0; i < LEN; i++) buckets[i*SYM_W +: SYM_W] = 8'(bv[i]);
  endtask

  // Reference key: plain modular / padded arithmetic on the rank array.
  function automatic logic [23:0] model_key(int i, int off, bit cyc);
    int sec;
    if (cyc)                sec = bv[(i + off) % LEN];
    else if (i + off < LEN) sec = bv[i + off];
    else                    sec = int'(PAD);
    return {8'(i), 8'(bv[i]), 8'(sec)};
  endfunction

  // One pass: mode 0 = ready high, 1 = ready 1,0,0 repeating, 2 = random.
  // inject_start pulses start with another offset mid-pass; abort_at resets after that many keys.
  task automatic do_pass(input int off, input bit cyc, input int mode,
                         input bit inject_start, input int abort_at);
    int cyc_cnt, exp_red, i, pat, budget;
    bit rdy, prev_stall;
    logic [23:0] prev_data, exp;
    exp_red = (cyc && off >= LEN) ? (off - LEN + 1 + LEN - 1) / LEN : 0;
    offset = 8'(off); cyclic = cyc; start = 1'b1; key_ready = 1'b0;
    step();
    start = 1'b0;
    cyc_cnt = 1;
    while (!key_valid && cyc_cnt < 300) begin
      n_checks++;
      if (busy !== 1'b1) $display("FAIL reduce_busy: busy=%b required 1", busy);
      else n_pass++;
      step();
      cyc_cnt++;
    end
    n_checks++;
    if (cyc_cnt !== 1 + exp_red)
      $display("FAIL first_key_latency off=%0d cyc=%0d: got %0d cycles required %0d",
               off, cyc, cyc_cnt, 1 + exp_red);
    else n_pass++;

    i = 0; pat = 0; budget = 0; prev_stall = 0; prev_data = '0;
    while (i < LEN && budget < 400) begin
      budget++;
      if (inject_start && i == 2) begin
        start = 1'b1; offset = 8'(off + 3);
      end else start = 1'b0;
      exp = model_key(i, off, cyc);
      n_checks++;
      if (key_valid !== 1'b1 || key_data !== exp)
        $display("FAIL key i=%0d: valid=%b data=%h required valid=1 data=%h", i, key_valid, key_data, exp);
      else n_pass++;
      n_checks++;
      if (key_last !== (i == LEN - 1))
        $display("FAIL key_last i=%0d: got %b required %b", i, key_last, i == LEN - 1);
      else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if (key_data !== prev_data)
          $display("FAIL stall_stable i=%0d: got %h required %h", i, key_data, prev_data);
        else n_pass++;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (pat % 3) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pat++;
      key_ready = rdy;
      prev_stall = !rdy;
      prev_data = key_data;
      if (rdy) i++;
      step();
      if (abort_at >= 0 && i == abort_at) begin
        start = 1'b0; key_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({key_valid, key_last, busy, done} !== 4'b0 || key_data !== '0)
          $display("FAIL abort_outputs: v=%b l=%b b=%b d=%b data=%h required all 0",
                   key_valid, key_last, busy, done, key_data);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
          step();
          n_checks++;
          if (done !== 1'b0 || key_valid !== 1'b0)
            $display("FAIL abort_quiet cycle %0d: done=%b valid=%b required 0", k, done, key_valid);
          else n_pass++;
        end
        return;
      end
    end
    start = 1'b0; key_ready = 1'b0;
    n_checks++;
    if (i !== LEN) $display("FAIL handshake_count: got %0d required %0d", i, LEN);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL done_pulse: done=%b valid=%b busy=%b required 1,0,1", done, key_valid, busy);
    else n_pass++;
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b0)
      $display("FAIL idle_after_done: done=%b busy=%b valid=%b required 0,0,0", done, busy, key_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cyclic = 1'b0; offset = '0; key_ready = 1'b0; buckets = '0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({key_valid, key_last, busy, done} !== 4'b0 || key_data !== '0)
      $display("FAIL reset_state: v=%b l=%b b=%b d=%b data=%h required all 0",
               key_valid, key_last, busy, done, key_data);
    else n_pass++;
  endtask

  task automatic set_ascending();
    for (int i = 0; i < LEN; i++) bv[i] = 10 + i;
    load_buckets();
  endtask

  task automatic test_linear();          set_ascending(); do_pass(2, 0, 0, 0, -1);  endtask
  task automatic test_cyclic_reduce();   set_ascending(); do_pass(18, 1, 0, 0, -1); endtask
  task automatic test_linear_pad();      set_ascending(); do_pass(9, 0, 0, 0, -1);  endtask
  task automatic test_backpressure();    set_ascending(); do_pass(0, 0, 1, 0, -1);  endtask
  task automatic test_start_during_busy(); set_ascending(); do_pass(3, 1, 0, 1, -1); endtask
  task automatic test_max_offset();      set_ascending(); do_pass(255, 1, 0, 0, -1); do_pass(255, 0, 0, 0, -1); endtask

  task automatic test_reset_mid_pass();
    set_ascending();
    do_pass(2, 0, 0, 0, 4);
    do_pass(5, 1, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < LEN; i++) bv[i] = int'($urandom_range(0, 255));
      load_buckets();
      do_pass(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 2, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_cyclic_reduce();
    test_linear_pad();
    test_backpressure();
    test_start_during_busy();
    test_max_offset();
    test_reset_mid_pass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
